// File: rtl/aes_arb_pkg.sv
// Shared types and constants for the AES core arbiter: FSM states, port count,
// and timeout sizing.
package aes_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_e;

  localparam int unsigned NPORTS             = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DEF_TMR_W          = $clog2(DEF_TIMEOUT_CYCLES);

  function automatic int unsigned tmr_width(input int unsigned cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/rr_picker2.sv
// Combinational 2-way round-robin pick: a lone requester wins, a tie goes to
// the port that was not granted last.
module rr_picker2
  import aes_arb_pkg::*;
(
  input  logic [NPORTS-1:0] valid,
  input  logic              last_grant,
  output logic              grant_valid,
  output logic              grant_id
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = 1'b0;
    case (valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one AES core between the UART command path (port 0) and the test-vector
// source (port 1); sequences start/ready, returns ciphertext, drives the scope trigger.
module aes_arbiter
  import aes_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NPORTS-1:0] req_valid,
  input  logic [127:0]      req_pt0,
  input  logic [127:0]      req_pt1,
  output logic [NPORTS-1:0] req_ready,
  output logic [NPORTS-1:0] rsp_valid,
  input  logic [NPORTS-1:0] rsp_ready,
  output logic [127:0]      rsp_ct,
  output logic              rsp_err,
  input  logic              aes_ready,
  output logic              aes_start,
  output logic [127:0]      pt_to_aes,
  input  logic [127:0]      ct_from_aes,
  output logic              trigger,
  output logic              timeout_err,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned      TMR_W    = tmr_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state;
  logic             gnt;
  logic             last_grant;
  logic [TMR_W-1:0] timer;
  logic             pick_valid;
  logic             pick_id;
  logic             accept;
  logic             rsp_hs;
  logic             abort;

  rr_picker2 u_picker (
    .valid       (req_valid),
    .last_grant  (last_grant),
    .grant_valid (pick_valid),
    .grant_id    (pick_id)
  );

  // Grant only when the core reports idle; reset also masks the accept path.
  always_comb begin
    req_ready = '0;
    if (reset && state == ST_IDLE && aes_ready && pick_valid)
      req_ready[pick_id] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == ST_RESP)
      rsp_valid[gnt] = 1'b1;
  end

  assign accept    = |(req_ready & req_valid);
  assign rsp_hs    = (state == ST_RESP) && rsp_ready[gnt];
  assign aes_start = (state == ST_START);

  // A normal exit in the expiry cycle takes priority over the abort.
  assign abort = (timer == TMR_LAST) &&
                 (((state == ST_WAIT_BUSY) && aes_ready) ||
                  ((state == ST_WAIT_DONE) && !aes_ready));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      timer       <= '0;
      pt_to_aes   <= '0;
      rsp_ct      <= '0;
      rsp_err     <= 1'b0;
      trigger     <= 1'b0;
      timeout_err <= 1'b0;
      op_count    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            pt_to_aes <= pick_id ? req_pt1 : req_pt0;
            gnt       <= pick_id;
            trigger   <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          timer <= '0;
          state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_WAIT_DONE: begin
          // Timer spans both wait states and saturates at the last count.
          if (timer != TMR_LAST)
            timer <= timer + 1'b1;
          if (abort) begin
            rsp_ct      <= '0;
            rsp_err     <= 1'b1;
            timeout_err <= 1'b1;
            trigger     <= 1'b0;
            state       <= ST_RESP;
          end else if (state == ST_WAIT_BUSY) begin
            if (!aes_ready)
              state <= ST_WAIT_DONE;
          end else if (aes_ready) begin
            rsp_ct  <= ct_from_aes;
            rsp_err <= 1'b0;
            trigger <= 1'b0;
            state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_hs) begin
            last_grant <= gnt;
            op_count   <= op_count + 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/aes_arbiter.md
# aes_arbiter

Sequencer and 2-way round-robin arbiter that shares the single AES core between two plaintext requesters: port 0 is the UART command path (the control block) and port 1 is the on-board test-vector source. It accepts one plaintext at a time and drives the core's start/ready handshake. It returns the ciphertext to the granted requester and raises a scope trigger window around each encryption for side-channel capture. A timeout recovers from a core that never starts or never finishes.

## Interface
- TIMEOUT_CYCLES, 4096: maximum cycles spent in WAIT_BUSY plus WAIT_DONE before the operation is aborted; must be ≥ 2.
- CNT_W, 16: width of op_count.

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); release is synchronous to clk
- req_valid  in  2  per-port plaintext valid, bit n = port n
- req_pt0, req_pt1  in  128 each  plaintext for ports 0 and 1
- req_ready  out  2  per-port accept; a transfer occurs on valid & ready
- rsp_valid  out  2  per-port response valid
- rsp_ready  in  2  per-port response accept
- rsp_ct  out  128  ciphertext, shared by both ports, qualified by rsp_valid
- rsp_err  out  1  response is a timeout abort, qualified by rsp_valid
- aes_ready  in  1  core idle/done
- aes_start  out  1  one-cycle start pulse to the core
- pt_to_aes  out  128  registered plaintext to the core
- ct_from_aes  in  128  core ciphertext
- trigger  out  1  scope trigger window
- timeout_err  out  1  sticky timeout flag; cleared only by reset
- op_count  out  CNT_W  completed operations, including aborts; wraps

## Operation
- Reset values: every output is 0, the FSM is in IDLE, and last_grant = 1, so port 0 wins the first tie.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Grant is computed only while aes_ready = 1.
  - If one port is valid, that port is granted.
  - If both ports are valid, the port ≠ last_grant is granted.
  - req_ready[g] = 1 combinationally for the granted port only. It may depend on req_valid and aes_ready.
  - On transfer: pt_to_aes ← req_ptg, gnt ← g, go to START.
  - If aes_ready = 0 (core still busy, e.g. after a reset mid-operation), nothing is granted.
- START: aes_start = 1 and trigger rises; timer cleared; go to WAIT_BUSY.
- WAIT_BUSY: wait for aes_ready = 0, then go to WAIT_DONE. A high aes_ready in this state is ignored as stale.
- WAIT_DONE: on aes_ready = 1, capture rsp_ct ← ct_from_aes, set rsp_err = 0, drop trigger, go to RESP.
- Timeout:
  - The timer counts every cycle in WAIT_BUSY and WAIT_DONE.
  - When timer = TIMEOUT_CYCLES−1 and no exit condition holds that cycle: rsp_ct ← 0, rsp_err ← 1, timeout_err ← 1, trigger drops, go to RESP.
  - If the exit condition and timer expiry coincide, the normal exit wins.
- RESP:
  - rsp_valid[gnt] = 1; rsp_ct and rsp_err are held stable until rsp_ready[gnt].
  - On handshake: last_grant ← gnt, op_count increments (wraps 2^CNT_W−1 → 0), go to IDLE.
  - No new request is accepted while in RESP.
- pt_to_aes holds its value from the accept until the next accept.
- Asserting reset in any state aborts the operation immediately. All outputs return to reset values and no response is delivered.

## Timing
- Transfer on edge E0. aes_start and trigger are high in cycle E0+1; pt_to_aes is valid from E0+1.
- The earliest aes_ready low that is honoured is sampled in E0+2.
- With aes_ready high again sampled in cycle Cd: trigger = 0 and rsp_valid = 1 from Cd+1.
- Fixed overhead is 3 cycles plus core latency. A consumer with rsp_ready tied high gets a back-to-back accept possible at Cd+2.
- The timeout fires exactly TIMEOUT_CYCLES cycles after entering WAIT_BUSY; rsp_valid rises on the following cycle.

## Structure
- Package aes_arb_pkg holds:
  - the state enum;
  - the port count constant NPORTS = 2;
  - the default TIMEOUT_CYCLES;
  - the timer width $clog2(TIMEOUT_CYCLES).
- One sub-module, rr_picker2: a combinational 2-way round-robin grant from (valid[1:0], last_grant) → (grant_valid, grant_id).
- The FSM, timer, registers and counter live in aes_arbiter.

## Test plan
- Single op, port 0: pt = 00112233445566778899aabbccddeeff. The core stub drops ready 1 cycle after start and raises it after 10 cycles with ct = ~pt. Required: rsp_valid[0] with rsp_ct = ffeeddccbbaa99887766554433221100, rsp_err = 0, trigger high for exactly 12 cycles, op_count = 1.
- Both ports valid continuously for 4 ops: grants are 0,1,0,1. Each response goes only to the granted port; rsp_valid of the other port stays 0.
- Core never drops ready after start, TIMEOUT_CYCLES = 16: rsp_valid rises 17 cycles after aes_start with rsp_ct = 0, rsp_err = 1; timeout_err stays 1 through the next good op.
- rsp_ready[1] held low for 50 cycles: rsp_ct and rsp_err stay stable, req_ready = 0 throughout, and port 0 is granted immediately after the handshake.
- Reset asserted in WAIT_DONE while the core is busy: all outputs go to 0 asynchronously. After release, a pending req_valid[0] is not accepted until aes_ready returns high.
- op_count wrap with CNT_W = 2: after 4 ops op_count = 0.
